// File: rtl/mips_io_responder.sv
// rtl/mips_io_responder.sv - peripheral side of the MIPS byte I/O port: inbound FIFO with interrupt, outbound holding register
module mips_io_responder #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLDOFF_CYC = 3
) (
  input  logic              Input_Clk,
  input  logic              Reset_n,
  input  logic              ext_valid,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ready,
  output logic [DATA_W-1:0] Data_in,
  output logic              Interrupt,
  input  logic              Int_Ack,
  input  logic [DATA_W-1:0] Data_out,
  input  logic              Out_Wr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              rx_overflow,
  output logic              tx_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        hold_q, hold_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              rx_overflow_q, rx_overflow_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              tx_overrun_q, tx_overrun_d;
  logic              push, pop;

  assign ext_ready   = (count_q != FULL_CNT);
  assign Interrupt   = (state_q == ST_ASSERT);
  assign Data_in     = data_in_q;
  assign rx_overflow = rx_overflow_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign tx_overrun  = tx_overrun_q;

  always_comb begin
    push          = ext_valid && ext_ready;
    pop           = (state_q == ST_ASSERT) && Int_Ack && (count_q != '0);
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rx_overflow_d = rx_overflow_q | (ext_valid && !ext_ready);
    if (push) begin
      mem_d[wr_ptr_q] = ext_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Head byte is presented one cycle after it changes; empty FIFO reads as zero.
    data_in_d = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (Int_Ack) begin
          state_d = ST_HOLDOFF;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (hold_q == 4'd0) state_d = ST_IDLE;
        else                hold_d  = hold_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    tx_overrun_d = tx_overrun_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = Out_Wr;
      if (Out_Wr) out_data_d = Data_out;
    end else if (Out_Wr && !out_valid_q) begin
      out_valid_d = 1'b1;
      out_data_d  = Data_out;
    end else if (Out_Wr) begin
      tx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Input_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= 4'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_in_q     <= '0;
      rx_overflow_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      tx_overrun_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_in_q     <= data_in_d;
      rx_overflow_q <= rx_overflow_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      tx_overrun_q  <= tx_overrun_d;
      mem_q         <= mem_d;
    end
  end

endmodule
